// File: rtl/bist_ctrl.sv
// BIST sequencer: LFSR pattern run, MISR flush, signature compare.
// Optional abort input enabled by defining BIST_CTRL_ABORT_EN.
module bist_ctrl #(
    parameter int unsigned          PAT_NUM    = 127,
    parameter int unsigned          LAT        = 2,
    parameter int unsigned          SIG_LEN    = 7,
    parameter logic [SIG_LEN-1:0]   GOLDEN_SIG = SIG_LEN'(7'h5A)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
`ifdef BIST_CTRL_ABORT_EN
    input  logic               abort,
`endif
    input  logic [SIG_LEN-1:0] sig_in,
    output logic               lfsr_rst,
    output logic               lfsr_en,
    output logic               misr_rst,
    output logic               misr_en,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [7:0]         pat_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        CMP   = 3'd4,
        DONE  = 3'd5
    } state_e;

    localparam logic [7:0] PAT_LAST = 8'(PAT_NUM - 1);
    localparam logic [7:0] PAT_MAX  = 8'(PAT_NUM);
    localparam logic [2:0] FL_LAST  = 3'(LAT - 1);

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [2:0]       flush_q, flush_d;
    logic [LAT-1:0]   sr_q, sr_d;
    logic             pass_q, pass_d;
    logic             abort_w;

`ifdef BIST_CTRL_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // Moore outputs: decoded only from registered state
    assign lfsr_rst = (state_q == INIT);
    assign misr_rst = (state_q == INIT);
    assign lfsr_en  = (state_q == RUN);
    assign misr_en  = sr_q[LAT-1];
    assign busy     = (state_q != IDLE) && (state_q != DONE);
    assign done     = (state_q == DONE);
    assign pass     = pass_q;
    assign pat_cnt  = cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flush_d = flush_q;
        pass_d  = pass_q;
        sr_d    = (sr_q << 1) | LAT'(lfsr_en);
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = INIT;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                    flush_d = '0;
                end
            end
            INIT: begin
                state_d = RUN;
                cnt_d   = '0;
            end
            RUN: begin
                if (cnt_q < PAT_MAX) cnt_d = cnt_q + 8'd1;
                if (cnt_q == PAT_LAST) begin
                    state_d = FLUSH;
                    flush_d = '0;
                end
            end
            FLUSH: begin
                if (flush_q == FL_LAST) begin
                    state_d = CMP;
                    flush_d = '0;
                end else begin
                    flush_d = flush_q + 3'd1;
                end
            end
            CMP: begin
                pass_d  = (sig_in == GOLDEN_SIG);
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (abort_w && busy) begin
            state_d = IDLE;
            cnt_d   = '0;
            flush_d = '0;
            pass_d  = 1'b0;
            sr_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            flush_q <= '0;
            sr_q    <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            sr_q    <= sr_d;
            pass_q  <= pass_d;
        end
    end

endmodule

// File: tb/tb_bist_ctrl.sv
// Directed bench for bist_ctrl: default config plus a PAT_NUM=1/LAT=1 copy.
module tb_bist_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, start1;
    logic [6:0] sig_in, sig1;
    logic       lfsr_rst, lfsr_en, misr_rst, misr_en, busy, done, pass;
    logic [7:0] pat_cnt;
    logic       lr1, le1, mr1, me1, b1, d1, p1;
    logic [7:0] pc1;
`ifdef BIST_CTRL_ABORT_EN
    logic       abort, abort1;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    bist_ctrl u_dut (
        .clk(clk), .reset(reset), .start(start),
`ifdef BIST_CTRL_ABORT_EN
        .abort(abort),
`endif
        .sig_in(sig_in), .lfsr_rst(lfsr_rst), .lfsr_en(lfsr_en),
        .misr_rst(misr_rst), .misr_en(misr_en), .busy(busy),
        .done(done), .pass(pass), .pat_cnt(pat_cnt)
    );

    bist_ctrl #(.PAT_NUM(1), .LAT(1)) u_small (
        .clk(clk), .reset(reset), .start(start1),
`ifdef BIST_CTRL_ABORT_EN
        .abort(abort1),
`endif
        .sig_in(sig1), .lfsr_rst(lr1), .lfsr_en(le1),
        .misr_rst(mr1), .misr_en(me1), .busy(b1),
        .done(d1), .pass(p1), .pat_cnt(pc1)
    );

    typedef struct {
        int   c;
        logic lrst;
        logic len;
        logic men;
        logic bsy;
        logic dn;
        int   pc;
    } vec_t;

    vec_t vecs[12];

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h",
                     nm, cyc, act, exp);
        end
    endtask

    // start pulse in the current cycle; leaves cyc=0 at the pulse
    task automatic pulse_start();
        start = 1'b1;
        cyc   = 0;
        step();
        start = 1'b0;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    initial begin
        int n, cl, cm, dcyc;
        reset  = 1'b1;
        start  = 1'b0;
        start1 = 1'b0;
        sig_in = 7'h5A;
        sig1   = 7'h5A;
`ifdef BIST_CTRL_ABORT_EN
        abort  = 1'b0;
        abort1 = 1'b0;
`endif
        vecs[0]  = '{0,   0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1,   1, 0, 0, 1, 0, 0};
        vecs[2]  = '{2,   0, 1, 0, 1, 0, 0};
        vecs[3]  = '{3,   0, 1, 0, 1, 0, 1};
        vecs[4]  = '{4,   0, 1, 1, 1, 0, 2};
        vecs[5]  = '{60,  0, 1, 1, 1, 0, 58};
        vecs[6]  = '{128, 0, 1, 1, 1, 0, 126};
        vecs[7]  = '{129, 0, 0, 1, 1, 0, 127};
        vecs[8]  = '{130, 0, 0, 1, 1, 0, 127};
        vecs[9]  = '{131, 0, 0, 0, 1, 0, 127};
        vecs[10] = '{132, 0, 0, 0, 0, 1, 127};
        vecs[11] = '{135, 0, 0, 0, 0, 1, 127};

        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_pat_cnt", pat_cnt, 0);
        chk("rst_misr_en", misr_en, 0);

        // main run, table driven; pulse is at cycle 0
        start = 1'b1;
        cyc   = 0;
        for (int i = 0; i < 12; i++) begin
            run_to(vecs[i].c);
            if (cyc == 1) start = 1'b0;
            chk($sformatf("v%0d_lfsr_rst", i), lfsr_rst, vecs[i].lrst);
            chk($sformatf("v%0d_misr_rst", i), misr_rst, vecs[i].lrst);
            chk($sformatf("v%0d_lfsr_en", i), lfsr_en, vecs[i].len);
            chk($sformatf("v%0d_misr_en", i), misr_en, vecs[i].men);
            chk($sformatf("v%0d_busy", i), busy, vecs[i].bsy);
            chk($sformatf("v%0d_done", i), done, vecs[i].dn);
            chk($sformatf("v%0d_pat_cnt", i), pat_cnt, vecs[i].pc);
        end
        chk("pass_golden", pass, 1);

        // rerun from DONE with a bad signature
        sig_in = 7'h5B;
        pulse_start();
        chk("rerun_pass_clr", pass, 0);
        chk("rerun_done_clr", done, 0);
        run_to(132);
        chk("bad_done", done, 1);
        chk("bad_pass", pass, 0);

        // synchronous reset mid-run
        sig_in = 7'h5A;
        pulse_start();
        run_to(60);
        chk("pre_rst_busy", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_lfsr_en", lfsr_en, 0);
        chk("mid_rst_misr_en", misr_en, 0);
        chk("mid_rst_pat_cnt", pat_cnt, 0);
        chk("mid_rst_pass", pass, 0);
        step();
        chk("idle_stays", busy, 0);
        pulse_start();
        n = 0;
        while (!done && cyc < 300) step();
        chk("post_rst_latency", cyc, 132);

        // start held high: back-to-back runs with 1-cycle DONE
        start = 1'b1;
        cyc   = 0;
        run_to(132);
        chk("held_done1", done, 1);
        step();
        chk("held_init_done", done, 0);
        chk("held_init_rst", lfsr_rst, 1);
        run_to(264);
        chk("held_done2", done, 1);
        chk("held_pat_cnt", pat_cnt, 127);
        start = 1'b0;
        step();
        chk("held_release", done, 1);

        // start pulse during RUN is ignored
        pulse_start();
        run_to(50);
        start = 1'b1;
        step();
        start = 1'b0;
        run_to(131);
        chk("run_pulse_131", done, 0);
        step();
        chk("run_pulse_132", done, 1);
        step();
        chk("run_pulse_held", done, 1);

        // PAT_NUM=1, LAT=1 instance
        cl = 0; cm = 0; dcyc = -1;
        start1 = 1'b1;
        cyc    = 0;
        step();
        start1 = 1'b0;
        while (cyc < 10) begin
            if (le1) cl++;
            if (me1) cm++;
            if (d1 && dcyc < 0) dcyc = cyc;
            step();
        end
        chk("small_lfsr_cycles", cl, 1);
        chk("small_misr_cycles", cm, 1);
        chk("small_done_cyc", dcyc, 5);
        chk("small_pat_cnt", pc1, 1);
        chk("small_pass", p1, 1);

        // abort at RUN cycle 10 (or a normal run without the feature)
        pulse_start();
        run_to(11);
`ifdef BIST_CTRL_ABORT_EN
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_pass", pass, 0);
        chk("abort_pat_cnt", pat_cnt, 0);
        chk("abort_misr_en", misr_en, 0);
        step();
        step();
        chk("abort_idle", busy, 0);
`else
        while (!done && cyc < 300) step();
        chk("noabort_latency", cyc, 132);
        chk("noabort_pass", pass, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
